// File: rtl/mac_dump_quantizer_if.sv
// Tap-side handshake, MAC accumulator/clear lines and sample output stream of the MAC dump stage.
// The master side drives taps and accepts samples; the slave side is the dump/quantizer block.
interface mac_dump_quantizer_if #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned OUT_W = 16
);
  logic             tap_valid;
  logic             tap_ready;
  logic [ACC_W-1:0] acc_in;
  logic             mac_clr;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             sat_flag;

  modport master (
    output tap_valid, acc_in, out_ready,
    input  tap_ready, mac_clr, out_valid, out_data, sat_flag
  );

  modport slave (
    input  tap_valid, acc_in, out_ready,
    output tap_ready, mac_clr, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/mac_dump_quantizer.sv
// Counts NUM_TAPS accepted MAC products, captures the settled accumulator, clears the MAC and
// pushes a rounded, saturated sample into a 2-entry output FIFO.
module mac_dump_quantizer #(
  parameter int unsigned NUM_TAPS = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned SHIFT    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_dump_quantizer_if.slave  bus
);

  localparam int unsigned CntW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic signed [ACC_W:0] Half = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MaxV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MinV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StAccum, StDump, StClear} state_e;

  state_e            state_q;
  logic [CntW-1:0]   tap_cnt_q;
  logic              tap_ready_q;
  logic              mac_clr_q;

  logic [OUT_W-1:0]  mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;
  logic              sat_q;

  logic              tap_accept;
  logic              can_push;
  logic              push;
  logic              pop;

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;
  logic                  clamp_hi;
  logic                  clamp_lo;
  logic [OUT_W-1:0]      q_data;

  always_comb begin
    tap_accept = bus.tap_valid & tap_ready_q;
    pop        = (count_q != 2'd0) & bus.out_ready;
    // A full buffer still accepts a capture when its head leaves in the same cycle.
    can_push   = (count_q != 2'd2) | bus.out_ready;
    push       = (state_q == StDump) & can_push;
  end

  // Quantizer: one extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    acc_ext  = {bus.acc_in[ACC_W-1], bus.acc_in};
    rounded  = acc_ext + Half;
    shifted  = rounded >>> SHIFT;
    clamp_hi = shifted > MaxV;
    clamp_lo = shifted < MinV;
    if (clamp_hi) begin
      q_data = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (clamp_lo) begin
      q_data = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      q_data = shifted[OUT_W-1:0];
    end
  end

  // Control FSM; tap_ready and mac_clr are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StClear;
      tap_cnt_q   <= '0;
      tap_ready_q <= 1'b0;
      mac_clr_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (tap_accept) begin
            if (tap_cnt_q == CntW'(NUM_TAPS - 1)) begin
              tap_cnt_q   <= '0;
              state_q     <= StDump;
              tap_ready_q <= 1'b0;
            end else begin
              tap_cnt_q <= tap_cnt_q + 1'b1;
            end
          end
        end
        StDump: begin
          if (can_push) begin
            state_q   <= StClear;
            mac_clr_q <= 1'b1;
          end
        end
        StClear: begin
          state_q     <= StAccum;
          mac_clr_q   <= 1'b0;
          tap_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StClear;
          tap_ready_q <= 1'b0;
          mac_clr_q   <= 1'b1;
        end
      endcase
    end
  end

  // Output FIFO. When full, wr_ptr equals rd_ptr, so a push+pop overwrites the departing head.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sat_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= q_data;
        wr_ptr_q        <= ~wr_ptr_q;
        sat_q           <= sat_q | clamp_hi | clamp_lo;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (!push && pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign bus.tap_ready = tap_ready_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_mac_dump_quantizer.sv
// Bench for mac_dump_quantizer: MAC model upstream, sample scoreboard downstream, directed
// corner cases followed by randomized taps, back-pressure and occasional resets.
module tb_mac_dump_quantizer;

  localparam int unsigned NUM_TAPS = 4;
  localparam int unsigned ACC_W    = 40;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned SHIFT    = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mac_dump_quantizer_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  mac_dump_quantizer #(
    .NUM_TAPS (NUM_TAPS),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .SHIFT    (SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  longint           prod = 0;
  bit               rnd_ready = 1'b0;
  int               errors = 0;
  int               checks = 0;
  int               pops = 0;
  logic [OUT_W-1:0] last_popped = '0;

  // Reference: expected samples in order, sticky saturation, running tap sum and count.
  logic [OUT_W-1:0] exp_q [$];
  bit               msat = 1'b0;
  longint           msum = 0;
  int               mcnt = 0;

  // MAC: accumulates accepted products, cleared by mac_clr.
  always @(posedge clk) begin
    if (bus.mac_clr) bus.acc_in <= '0;
    else if (bus.tap_valid && bus.tap_ready) bus.acc_in <= bus.acc_in + ACC_W'(prod);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] quant(input longint s, output bit clamped);
    longint r, mx, mn;
    r  = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    mn = -(longint'(1) <<< (OUT_W - 1));
    clamped = (r > mx) || (r < mn);
    if (r > mx) return OUT_W'(mx);
    if (r < mn) return OUT_W'(mn);
    return OUT_W'(r);
  endfunction

  task automatic sample();
    bit c;
    if (reset) begin
      exp_q.delete();
      msum = 0;
      mcnt = 0;
      msat = 1'b0;
      return;
    end
    // While accepting taps every completed sample has been pushed.
    if (bus.tap_ready) begin
      chk("sat_flag", bus.sat_flag, msat);
      chk("out_valid_accum", bus.out_valid, exp_q.size() != 0);
    end
    if (bus.out_valid) begin
      chk("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("out_data", bus.out_data, exp_q[0]);
        if (bus.out_ready) begin
          last_popped = bus.out_data;
          pops++;
          void'(exp_q.pop_front());
        end
      end
    end
    if (bus.tap_valid && bus.tap_ready) begin
      msum += prod;
      mcnt++;
      if (mcnt == NUM_TAPS) begin
        exp_q.push_back(quant(msum, c));
        msat = msat | c;
        msum = 0;
        mcnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_tap(input longint p);
    bit acc = 1'b0;
    int guard = 0;
    bus.tap_valid = 1'b1;
    prod = p;
    while (!acc && guard < 200) begin
      acc = bus.tap_ready;
      tick();
      guard++;
    end
    chk("tap_accept_timeout", acc, 1);
    bus.tap_valid = 1'b0;
    prod = 0;
  endtask

  task automatic wait_pop();
    int start = pops;
    int guard = 0;
    while (pops == start && guard < 50) begin
      tick();
      guard++;
    end
    chk("pop_timeout", pops != start, 1);
  endtask

  task automatic send_sample(input longint p);
    for (int i = 0; i < NUM_TAPS; i++) send_tap(p);
  endtask

  function automatic longint rand_prod();
    return longint'(int'($urandom)) >>> $urandom_range(1, 24);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.tap_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_mac_clr", bus.mac_clr, 1);
    chk("rst_tap_ready", bus.tap_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    tick();
    chk("accum_tap_ready", bus.tap_ready, 1);
    chk("accum_mac_clr", bus.mac_clr, 0);

    // Sum 49152 -> 2, with exact dump latency.
    send_tap(10000);
    send_tap(20000);
    send_tap(15000);
    send_tap(4152);
    chk("k1_mac_clr", bus.mac_clr, 0);
    chk("k1_tap_ready", bus.tap_ready, 0);
    tick();
    chk("k2_mac_clr", bus.mac_clr, 1);
    chk("k2_out_valid", bus.out_valid, 1);
    tick();
    chk("k3_mac_clr", bus.mac_clr, 0);
    chk("k3_tap_ready", bus.tap_ready, 1);
    bus.out_ready = 1'b1;
    wait_pop();
    chk("sample_49152", last_popped, 16'h0002);
    chk("sat_after_49152", bus.sat_flag, 0);

    send_sample(longint'(1) <<< 28);
    wait_pop();
    chk("sample_2p30", last_popped, 16'h7FFF);
    chk("sat_after_2p30", bus.sat_flag, 1);

    send_sample(-8192);
    wait_pop();
    chk("sample_m32768", last_popped, 16'hFFFF);
    chk("sat_sticky", bus.sat_flag, 1);

    send_sample(-(longint'(1) <<< 36));
    wait_pop();
    chk("sample_m2p38", last_popped, 16'h8000);

    // Three dumps with no downstream consumer: the third stalls.
    bus.out_ready = 1'b0;
    for (int s = 1; s <= 3; s++) send_sample(s * 8192);
    repeat (3) tick();
    chk("stall_tap_ready", bus.tap_ready, 0);
    chk("stall_mac_clr", bus.mac_clr, 0);
    chk("stall_out_valid", bus.out_valid, 1);
    chk("stall_head", bus.out_data, 16'h0001);
    bus.out_ready = 1'b1;
    chk("pp_mac_clr_before", bus.mac_clr, 0);
    tick();
    bus.out_ready = 1'b0;
    chk("pp_popped", last_popped, 16'h0001);
    chk("pp_mac_clr_after", bus.mac_clr, 1);
    chk("pp_out_valid", bus.out_valid, 1);
    chk("pp_head", bus.out_data, 16'h0002);
    bus.out_ready = 1'b1;
    wait_pop();
    chk("drain_second", last_popped, 16'h0002);
    wait_pop();
    chk("drain_third", last_popped, 16'h0003);
    tick();
    chk("drain_out_valid", bus.out_valid, 0);
    chk("drain_queue", exp_q.size(), 0);

    // Reset after two taps discards the partial sum.
    send_tap(3 * 8192);
    send_tap(3 * 8192);
    reset = 1'b1;
    tick();
    chk("midrst_mac_clr", bus.mac_clr, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_tap_ready", bus.tap_ready, 0);
    reset = 1'b0;
    tick();
    chk("midrst_accum", bus.tap_ready, 1);
    send_sample(5 * 8192);
    wait_pop();
    chk("midrst_sample", last_popped, 16'h0005);

    // Randomized taps, gaps, back-pressure and rare resets.
    rnd_ready = 1'b1;
    for (int i = 0; i < 240; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
      end
      if ($urandom_range(0, 3) == 0) tick();
      send_tap(rand_prod());
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    chk("final_out_valid", bus.out_valid, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
